csm_iter_mult: RTL and testbench

Iterative, parametrised carry-save multiplier: multiplies two WIDTH-bit operands by processing one multiplier bit per clock through a single row of WIDTH AND/adder base cells. The running sum and carry are held in carry-save registers, then merged by one ripple-carry pass. It is the area-reduced sequential successor to the fully combinational carry-save array. It sits behind a valid/ready handshake so datapath blocks can stream operands into it.

---
 rtl/csm_iter_mult.sv | 162 ++++++++++++++++
 tb/tb_csm_iter_mult.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csm_iter_mult.sv
// Iterative carry-save multiplier: one multiplier bit per cycle, then a single ripple merge.
// Optional Baugh-Wooley signed mode (adds tc_i) is enabled by defining CSM_SIGNED_EN.
module csm_iter_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
`ifdef CSM_SIGNED_EN
    input  logic               tc_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               busy_o
);

    localparam int unsigned     CntW  = $clog2(WIDTH);
    localparam logic [CntW-1:0] KLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MsbMask = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StMerge,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   carry_q, carry_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               tc_act;
    logic               b_bit;
    logic               last_row;
    logic [WIDTH-1:0]   inv_mask;
    logic [WIDTH-1:0]   pp;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   row_sum;
    logic [WIDTH-1:0]   row_carry;
    logic [WIDTH-1:0]   hi_sum;
    logic               rc;

`ifdef CSM_SIGNED_EN
    logic tc_q, tc_d;
    assign tc_act = tc_q;
`else
    assign tc_act = 1'b0;
`endif

    assign b_bit    = b_q[cnt_q];
    assign last_row = (cnt_q == KLast);
    // Baugh-Wooley: invert a_msb*b_k (k<msb) and a_j*b_msb (j<msb), keep msb*msb.
    assign inv_mask = last_row ? ~MsbMask : MsbMask;
    assign pp       = (a_q & {WIDTH{b_bit}}) ^ (tc_act ? inv_mask : '0);
    assign sum_sh   = {1'b0, sum_q[WIDTH-1:1]};

    // One row of full-adder cells on (pp[j], sum[j+1], carry[j]).
    assign row_sum   = pp ^ sum_sh ^ carry_q;
    assign row_carry = (pp & sum_sh) | (pp & carry_q) | (sum_sh & carry_q);

    always_comb begin : merge_adder
        rc     = tc_act;
        hi_sum = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            hi_sum[j] = sum_sh[j] ^ carry_q[j] ^ rc;
            rc        = (sum_sh[j] & carry_q[j]) | (rc & (sum_sh[j] ^ carry_q[j]));
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
`ifdef CSM_SIGNED_EN
        tc_d    = tc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sum_d   = '0;
                    carry_d = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
`ifdef CSM_SIGNED_EN
                    tc_d    = tc_i;
`endif
                    state_d = StAccum;
                end
            end
            StAccum: begin
                sum_d       = row_sum;
                carry_d     = row_carry;
                lo_d[cnt_q] = row_sum[0];
                cnt_d       = cnt_q + 1'b1;
                if (last_row) begin
                    state_d = StMerge;
                end
            end
            StMerge: begin
                // Top-bit flip supplies the 2^(2W-1) correction term in signed mode.
                prod_d = {hi_sum[WIDTH-1] ^ tc_act, hi_sum[WIDTH-2:0], lo_q};
                state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
`ifdef CSM_SIGNED_EN
            tc_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`ifdef CSM_SIGNED_EN
            tc_q    <= tc_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StAccum) || (state_q == StMerge);
    assign prod_o      = prod_q;

endmodule

// File: tb/tb_csm_iter_mult.sv
// Bench for csm_iter_mult: directed table at WIDTH=8 plus back-to-back streams at WIDTH=2/8/16.
// Signed vectors are included when CSM_SIGNED_EN is defined.
module tb_csm_iter_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic        rst, in_valid, in_ready, tc, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] prod;
    logic [15:0] sb8[$];

    // streaming instances share their own reset
    logic        rst_s;
    logic        tc0 = 1'b0;
    logic        iv2, ir2, ov2, bz2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic [3:0]  sb2[$];
    logic        iv16, ir16, ov16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic [31:0] sb16[$];
    bit          done2 = 0, done16 = 0;

    csm_iter_mult #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b),
`ifdef CSM_SIGNED_EN
        .tc_i(tc),
`endif
        .out_valid_o(out_valid), .out_ready_i(out_ready), .prod_o(prod), .busy_o(busy)
    );

    csm_iter_mult #(.WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst_s), .in_valid_i(iv2), .in_ready_o(ir2),
        .a_i(a2), .b_i(b2),
`ifdef CSM_SIGNED_EN
        .tc_i(tc0),
`endif
        .out_valid_o(ov2), .out_ready_i(1'b1), .prod_o(p2), .busy_o(bz2)
    );

    csm_iter_mult #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst_s), .in_valid_i(iv16), .in_ready_o(ir16),
        .a_i(a16), .b_i(b16),
`ifdef CSM_SIGNED_EN
        .tc_i(tc0),
`endif
        .out_valid_o(ov16), .out_ready_i(1'b1), .prod_o(p16), .busy_o(bz16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        tc;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Starts at a negedge in IDLE; returns at a negedge after the product (and, if
    // out_ready is high, after the consuming edge).
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic tcv,
                          input logic [15:0] expv, input string name);
        int e;
        int busy_cnt;
        bit seen;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        tc       = tcv;
        sb8.push_back(expv);
        @(posedge clk);
        e = 0; busy_cnt = 0; seen = 0;
        while (e <= 100) begin
            @(negedge clk);
            if (e == 0) begin
                in_valid = 1'b0;
                a        = 8'($urandom);
                b        = 8'($urandom);
            end
            if (out_valid) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            e++;
        end
        if (!seen) begin
            fail_now({name, " done"});
            if (sb8.size() > 0) void'(sb8.pop_front());
        end else begin
            check({name, " latency"}, 32'(e), 32'd9);
            check({name, " busy_cycles"}, 32'(busy_cnt), 32'd9);
            check({name, " prod"}, 32'(prod), 32'(sb8.pop_front()));
            if (out_ready) begin
                @(posedge clk);
                @(negedge clk);
                check({name, " out_valid_drop"}, 32'(out_valid), 32'd0);
            end
        end
    endtask

    initial begin : main
        bit seen_ov;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0; out_ready = 1'b1;

        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff"});
        vecs.push_back('{8'h0D, 8'h0B, 1'b0, 16'h008F, "u_0d_0b"});
        vecs.push_back('{8'h03, 8'h05, 1'b0, 16'h000F, "u_03_05"});
        vecs.push_back('{8'h00, 8'h5A, 1'b0, 16'h0000, "u_00_5a"});
        vecs.push_back('{8'h01, 8'h01, 1'b0, 16'h0001, "u_01_01"});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000, "u_80_80"});
        vecs.push_back('{8'hA5, 8'h3C, 1'b0, 16'h26AC, "u_a5_3c"});
`ifdef CSM_SIGNED_EN
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80"});
        vecs.push_back('{8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_ff_01"});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080, "s_7f_80"});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_ff_ff"});
        vecs.push_back('{8'h05, 8'hFD, 1'b1, 16'hFFF1, "s_05_fd"});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 16'h4000, "s_tc0_80_80"});
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset prod", 32'(prod), 32'h0);
        check("reset busy", 32'(busy), 32'd0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].tc, vecs[i].exp, vecs[i].name);

        // Back-pressure: DONE holds, prod stable, in_valid ignored.
        out_ready = 1'b0;
        run_op(8'h0D, 8'h0B, 1'b0, 16'h008F, "bp");
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'(i % 2);
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp prod_stable", 32'(prod), 32'h008F);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp no_accept_in_done busy", 32'(busy), 32'd0);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of ACCUM.
        in_valid = 1'b1; a = 8'h12; b = 8'h34;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst prod", 32'(prod), 32'h0);
        seen_ov = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1;
        end
        check("midrst no_out_valid", 32'(seen_ov), 32'd0);
        run_op(8'h03, 8'h05, 1'b0, 16'h000F, "after_rst");

        // Back-to-back random stream at WIDTH=8.
        begin
            int n_acc, n_done, last_acc, guard;
            bit pend;
            n_acc = 0; n_done = 0; last_acc = -1; guard = 0; pend = 0;
            tc = 1'b0; in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            while (n_done < 12 && guard < 2000) begin
                if (out_valid) begin
                    if (sb8.size() == 0) fail_now("b2b8 empty_scoreboard");
                    else check("b2b8 prod", 32'(prod), 32'(sb8.pop_front()));
                    n_done++;
                end
                if (in_valid && in_ready) begin
                    sb8.push_back(16'(a) * 16'(b));
                    if (last_acc >= 0) check("b2b8 ii", 32'(cyc - last_acc), 32'd11);
                    last_acc = cyc;
                    n_acc++;
                    pend = 1;
                end
                @(negedge clk);
                guard++;
                if (pend) begin
                    a = 8'($urandom); b = 8'($urandom); pend = 0;
                    if (n_acc == 12) in_valid = 1'b0;
                end
            end
            if (n_done < 12) fail_now("b2b8 stream");
            in_valid = 1'b0;
        end

        for (int i = 0; i < 5000 && !(done2 && done16); i++) @(negedge clk);
        if (!(done2 && done16)) fail_now("streams finish");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stream2
        int n_acc, n_done, last_acc, guard;
        bit pend;
        rst_s = 1'b1; iv2 = 1'b0; a2 = '0; b2 = '0;
        iv16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        n_acc = 0; n_done = 0; last_acc = -1; guard = 0; pend = 0;
        iv2 = 1'b1; a2 = 2'($urandom); b2 = 2'($urandom);
        while (n_done < 20 && guard < 2000) begin
            if (ov2) begin
                if (sb2.size() == 0) fail_now("b2b2 empty_scoreboard");
                else check("b2b2 prod", 32'(p2), 32'(sb2.pop_front()));
                n_done++;
            end
            if (iv2 && ir2) begin
                sb2.push_back(4'(a2) * 4'(b2));
                if (last_acc >= 0) check("b2b2 ii", 32'(cyc - last_acc), 32'd5);
                last_acc = cyc;
                n_acc++;
                pend = 1;
            end
            @(negedge clk);
            guard++;
            if (pend) begin
                a2 = 2'($urandom); b2 = 2'($urandom); pend = 0;
                if (n_acc == 20) iv2 = 1'b0;
            end
        end
        if (n_done < 20) fail_now("b2b2 stream");
        iv2   = 1'b0;
        done2 = 1;
    end

    initial begin : stream16
        int n_acc, n_done, last_acc, guard;
        bit pend;
        @(negedge rst_s);
        @(negedge clk);
        n_acc = 0; n_done = 0; last_acc = -1; guard = 0; pend = 0;
        iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
        while (n_done < 10 && guard < 2000) begin
            if (ov16) begin
                if (sb16.size() == 0) fail_now("b2b16 empty_scoreboard");
                else check("b2b16 prod", p16, sb16.pop_front());
                n_done++;
            end
            if (iv16 && ir16) begin
                sb16.push_back(32'(a16) * 32'(b16));
                if (last_acc >= 0) check("b2b16 ii", 32'(cyc - last_acc), 32'd19);
                last_acc = cyc;
                n_acc++;
                pend = 1;
            end
            @(negedge clk);
            guard++;
            if (pend) begin
                a16 = 16'($urandom); b16 = 16'($urandom); pend = 0;
                if (n_acc == 10) iv16 = 1'b0;
            end
        end
        if (n_done < 10) fail_now("b2b16 stream");
        iv16   = 1'b0;
        done16 = 1;
    end

endmodule
